// File: rtl/ysyx_25020047_lsu_pkg.sv
// LSU shared types: FSM state codes, access size codes
// and the byte-strobe helper used by the align datapath.
package ysyx_25020047_lsu_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_REQ  = 2'd1;
  localparam state_t ST_WAIT = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  function automatic logic [3:0] byte_mask(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic [3:0] m;
    case (size)
      SZ_B:    m = 4'b0001 << off;
      SZ_H:    m = 4'b0011 << off;
      SZ_W:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = off[0];
      SZ_W:    bad = |off;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/ysyx_25020047_lsu_align.sv
// Store lane replication / strobes and load extract
// with sign or zero extension.
module ysyx_25020047_lsu_align
  import ysyx_25020047_lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        wen,
  input  logic        uns,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_word,
  output logic [3:0]  wmask,
  output logic [31:0] wdata,
  output logic [31:0] ld_data
);

  logic [31:0] sh;

  assign sh    = ld_word >> {off, 3'b000};
  assign wmask = wen ? byte_mask(size, off) : 4'b0000;

  always_comb begin
    wdata = st_data;
    unique case (1'b1)
      size == SZ_B: wdata = {4{st_data[7:0]}};
      size == SZ_H: wdata = {2{st_data[15:0]}};
      default:      wdata = st_data;
    endcase
  end

  always_comb begin
    ld_data = ld_word;
    unique case (1'b1)
      size == SZ_B:
        ld_data = uns ? {24'b0, sh[7:0]}
                      : {{24{sh[7]}}, sh[7:0]};
      size == SZ_H:
        ld_data = uns ? {16'b0, sh[15:0]}
                      : {{16{sh[15]}}, sh[15:0]};
      default:
        ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/ysyx_25020047_lsu.sv
// Load/store unit: one memory access in flight over a
// valid/ready request and a response strobe.
module ysyx_25020047_lsu
  import ysyx_25020047_lsu_pkg::*;
#(
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic        in_read,
  input  logic        in_write,
  input  logic [1:0]  in_size,
  input  logic        in_unsigned,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_wen,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_rdata,
  output logic        out_valid,
  output logic [31:0] out_rdata,
  output logic        out_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t          state;
  logic [31:0]     addr_q;
  logic [31:0]     wdata_q;
  logic            rd_q;
  logic            wr_q;
  logic            uns_q;
  logic [1:0]      size_q;
  logic [CW-1:0]   cnt;

  logic            accept;
  logic            in_bad;
  logic            tmo;
  logic [31:0]     ld_data;

  assign in_ready = (state == ST_IDLE);
  assign accept   = in_valid & in_ready;

  // a no-op (neither read nor write) is never flagged
  assign in_bad = (in_read | in_write) &
                  ((in_read & in_write) |
                   misaligned(in_size, in_addr[1:0]));

  // last cycle allowed in REQ+WAIT
  assign tmo = (cnt == CW'(TIMEOUT - 1));

  assign mem_req_valid = (state == ST_REQ);
  assign mem_req_addr  = {addr_q[31:2], 2'b00};
  assign mem_req_wen   = wr_q;

  ysyx_25020047_lsu_align u_align (
    .size    (size_q),
    .off     (addr_q[1:0]),
    .wen     (wr_q),
    .uns     (uns_q),
    .st_data (wdata_q),
    .ld_word (mem_resp_rdata),
    .wmask   (mem_req_wmask),
    .wdata   (mem_req_wdata),
    .ld_data (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      uns_q     <= 1'b0;
      size_q    <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      out_rdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            addr_q  <= in_addr;
            wdata_q <= in_wdata;
            rd_q    <= in_read;
            wr_q    <= in_write;
            uns_q   <= in_unsigned;
            size_q  <= in_size;
            cnt     <= '0;
            if (!in_read && !in_write) begin
              state     <= ST_DONE;
              out_valid <= 1'b1;
              out_err   <= 1'b0;
              out_rdata <= '0;
            end else if (in_bad) begin
              state     <= ST_DONE;
              out_valid <= 1'b1;
              out_err   <= 1'b1;
              out_rdata <= '0;
            end else begin
              state <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          cnt <= cnt + 1'b1;
          if (tmo) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
            out_err   <= 1'b1;
            out_rdata <= '0;
          end else if (mem_req_ready) begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt <= cnt + 1'b1;
          if (mem_resp_valid) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
            out_err   <= 1'b0;
            out_rdata <= rd_q ? ld_data : 32'b0;
          end else if (tmo) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
            out_err   <= 1'b1;
            out_rdata <= '0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
          out_err   <= 1'b0;
          out_rdata <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25020047_lsu.sv
// Directed + randomized bench for the LSU against an
// arithmetic reference of the access rules.
module tb_ysyx_25020047_lsu;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_addr = '0;
  logic [31:0] in_wdata = '0;
  logic        in_read = 1'b0;
  logic        in_write = 1'b0;
  logic [1:0]  in_size = '0;
  logic        in_unsigned = 1'b0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_rdata = '0;
  logic        out_valid;
  logic [31:0] out_rdata;
  logic        out_err;

  int vectors = 0;
  int miscompares = 0;

  ysyx_25020047_lsu #(.TIMEOUT(TMO)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_addr        (in_addr),
    .in_wdata       (in_wdata),
    .in_read        (in_read),
    .in_write       (in_write),
    .in_size        (in_size),
    .in_unsigned    (in_unsigned),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wen    (mem_req_wen),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_wmask  (mem_req_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata),
    .out_valid      (out_valid),
    .out_rdata      (out_rdata),
    .out_err        (out_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic logic bad_f(input logic [31:0] a,
                                 input logic rd, wr,
                                 input logic [1:0] sz);
    if (!rd && !wr) return 1'b0;
    if (rd && wr) return 1'b1;
    if (sz == 2'd3) return 1'b1;
    return (a % (32'd1 << sz)) != 0;
  endfunction

  function automatic logic [3:0] mask_f(input logic [31:0] a,
                                        input logic wr,
                                        input logic [1:0] sz);
    int nb;
    int m;
    if (!wr) return 4'b0000;
    nb = 1 << sz;
    m = ((1 << nb) - 1) << (a % 4);
    return 4'(m);
  endfunction

  function automatic logic [31:0] wdata_f(input logic [31:0] d,
                                          input logic [1:0] sz);
    if (sz == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
    if (sz == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] load_f(input logic [31:0] a,
                                         input logic [31:0] w,
                                         input logic [1:0] sz,
                                         input logic uns);
    logic [31:0] sh;
    int v;
    sh = w >> (8 * (a % 4));
    if (sz == 2'd0) begin
      v = $signed(sh[7:0]);
      return uns ? (sh & 32'hFF) : 32'(v);
    end
    if (sz == 2'd1) begin
      v = $signed(sh[15:0]);
      return uns ? (sh & 32'hFFFF) : 32'(v);
    end
    return w;
  endfunction

  task automatic access(input logic [31:0] a, d,
                        input logic rd, wr,
                        input logic [1:0] sz,
                        input logic uns,
                        input logic [31:0] word,
                        input int rdy_dly, rsp_dly,
                        output logic [31:0] got);
    logic bad;
    logic mem;
    int lat;
    bad = bad_f(a, rd, wr, sz);
    mem = (rd || wr) && !bad;
    @(negedge clk);
    check("idle_ready", {31'b0, in_ready}, 32'd1);
    check("idle_ov", {31'b0, out_valid}, 32'd0);
    in_valid = 1'b1;
    in_addr = a;
    in_wdata = d;
    in_read = rd;
    in_write = wr;
    in_size = sz;
    in_unsigned = uns;
    @(negedge clk);
    lat = 1;
    in_valid = 1'b0;
    in_addr = $urandom;
    in_wdata = $urandom;
    in_read = 1'($urandom);
    in_write = 1'($urandom);
    in_size = 2'($urandom);
    if (!mem) begin
      check("nomem_req", {31'b0, mem_req_valid}, 32'd0);
      check("nomem_ov", {31'b0, out_valid}, 32'd1);
      check("nomem_err", {31'b0, out_err}, {31'b0, bad});
      check("nomem_rdata", out_rdata, 32'd0);
      got = out_rdata;
    end else begin
      for (int k = 0; k <= rdy_dly; k++) begin
        check("req_valid", {31'b0, mem_req_valid}, 32'd1);
        check("req_addr", mem_req_addr, a & ~32'd3);
        check("req_wen", {31'b0, mem_req_wen}, {31'b0, wr});
        check("req_wmask", {28'b0, mem_req_wmask},
              {28'b0, mask_f(a, wr, sz)});
        if (wr)
          check("req_wdata", mem_req_wdata, wdata_f(d, sz));
        check("busy_ready", {31'b0, in_ready}, 32'd0);
        if (k == rdy_dly) mem_req_ready = 1'b1;
        @(negedge clk);
        lat++;
        mem_req_ready = 1'b0;
      end
      for (int k = 0; k < rsp_dly; k++) begin
        check("wait_req", {31'b0, mem_req_valid}, 32'd0);
        check("wait_ov", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        lat++;
      end
      mem_resp_valid = 1'b1;
      mem_resp_rdata = word;
      @(negedge clk);
      lat++;
      mem_resp_valid = 1'b0;
      mem_resp_rdata = $urandom;
      check("done_ov", {31'b0, out_valid}, 32'd1);
      check("done_err", {31'b0, out_err}, 32'd0);
      check("done_rdata", out_rdata,
            rd ? load_f(a, word, sz, uns) : 32'd0);
      check("latency", 32'(lat), 32'(3 + rdy_dly + rsp_dly));
      got = out_rdata;
    end
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] a;
    logic [31:0] d;
    logic        rd;
    logic        wr;
    logic [1:0]  sz;
    int          op;
    int          lat;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_ready", {31'b0, in_ready}, 32'd1);
    check("rst_req", {31'b0, mem_req_valid}, 32'd0);
    check("rst_ov", {31'b0, out_valid}, 32'd0);
    check("rst_err", {31'b0, out_err}, 32'd0);
    check("rst_rdata", out_rdata, 32'd0);
    check("rst_addr", mem_req_addr, 32'd0);
    check("rst_wen", {31'b0, mem_req_wen}, 32'd0);
    check("rst_wdata", mem_req_wdata, 32'd0);
    check("rst_wmask", {28'b0, mem_req_wmask}, 32'd0);

    access(32'h8000_0004, 32'h0, 1, 0, 2'd2, 0,
           32'hDEAD_BEEF, 0, 0, got);
    check("lw_lit", got, 32'hDEAD_BEEF);
    access(32'h8000_0003, 32'h0, 1, 0, 2'd0, 0,
           32'h80FF_1234, 0, 1, got);
    check("lb_lit", got, 32'hFFFF_FF80);
    access(32'h8000_0003, 32'h0, 1, 0, 2'd0, 1,
           32'h80FF_1234, 1, 0, got);
    check("lbu_lit", got, 32'h0000_0080);
    access(32'h8000_0002, 32'h0, 1, 0, 2'd1, 0,
           32'h80FF_1234, 0, 0, got);
    check("lh_lit", got, 32'hFFFF_80FF);
    access(32'h8000_0001, 32'h1234_56AB, 0, 1, 2'd0, 0,
           32'h0, 0, 0, got);
    check("sb_rdata", got, 32'd0);
    access(32'h8000_0002, 32'h1234_56AB, 0, 1, 2'd1, 0,
           32'h0, 2, 1, got);
    access(32'h8000_0002, 32'h0, 1, 0, 2'd2, 0,
           32'h0, 0, 0, got);
    access(32'h8000_0000, 32'h0, 0, 0, 2'd2, 0,
           32'h0, 0, 0, got);

    // held request, then timeout with no response
    @(negedge clk);
    in_valid = 1'b1;
    in_addr = 32'h8000_0011;
    in_wdata = 32'hCAFE_F00D;
    in_read = 1'b0;
    in_write = 1'b1;
    in_size = 2'd0;
    @(negedge clk);
    in_valid = 1'b0;
    in_addr = $urandom;
    in_wdata = $urandom;
    lat = 1;
    for (int k = 0; k < 5; k++) begin
      check("hold_valid", {31'b0, mem_req_valid}, 32'd1);
      check("hold_addr", mem_req_addr, 32'h8000_0010);
      check("hold_wmask", {28'b0, mem_req_wmask}, 32'h2);
      check("hold_wdata", mem_req_wdata, 32'h0D0D_0D0D);
      @(negedge clk);
      lat++;
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    lat++;
    mem_req_ready = 1'b0;
    for (int k = 0; k < 20 && !out_valid; k++) begin
      @(negedge clk);
      lat++;
    end
    check("tmo_ov", {31'b0, out_valid}, 32'd1);
    check("tmo_err", {31'b0, out_err}, 32'd1);
    check("tmo_req", {31'b0, mem_req_valid}, 32'd0);
    check("tmo_lat", 32'(lat), 32'(TMO + 1));
    @(negedge clk);
    mem_resp_valid = 1'b1;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    check("late_ov", {31'b0, out_valid}, 32'd0);

    // reset while waiting for a response
    in_valid = 1'b1;
    in_addr = 32'h8000_0020;
    in_read = 1'b1;
    in_write = 1'b0;
    in_size = 2'd2;
    @(negedge clk);
    in_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_ready", {31'b0, in_ready}, 32'd1);
    check("mrst_req", {31'b0, mem_req_valid}, 32'd0);
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'h1111_2222;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      mem_resp_valid = 1'b0;
      check("mrst_ov", {31'b0, out_valid}, 32'd0);
    end
    access(32'h8000_0024, 32'h0, 1, 0, 2'd2, 0,
           32'h1357_9BDF, 0, 0, got);
    check("post_rst_lw", got, 32'h1357_9BDF);

    for (int i = 0; i < 60; i++) begin
      a = $urandom;
      d = $urandom;
      sz = 2'($urandom_range(0, 3));
      op = $urandom_range(0, 9);
      rd = (op < 4) || (op == 9);
      wr = (op >= 4 && op < 8) || (op == 9);
      if ($urandom_range(0, 3) != 0 && sz != 2'd3)
        a = a & ~((32'd1 << sz) - 1);
      access(a, d, rd, wr, sz, 1'($urandom), $urandom,
             $urandom_range(0, 3), $urandom_range(0, 2), got);
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
